// File: rtl/regex_match_lane_pool.sv
// Multi-thread match stage: issues instruction fetches for (pc, cc_id) tokens, executes
// MATCH / NOT_MATCH / ACCEPT on in-order responses and buffers survivors as (pc+1, cc_id+1).
module regex_match_lane_pool #(
    parameter int PC_WIDTH          = 9,
    parameter int CC_ID_BITS        = 2,
    parameter int CHARACTER_WIDTH   = 8,
    parameter int MEMORY_WIDTH      = 16,
    parameter int MEMORY_ADDR_WIDTH = 11,
    parameter int OUTSTANDING_LOG2  = 2
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [(2**CC_ID_BITS)*CHARACTER_WIDTH-1:0]  current_characters,
    input  logic [2**CC_ID_BITS-1:0]                    end_of_string,
    input  logic                                        input_pc_valid,
    output logic                                        input_pc_ready,
    input  logic [PC_WIDTH-1:0]                         input_pc,
    input  logic [CC_ID_BITS-1:0]                       input_cc_id,
    output logic                                        mem_req_valid,
    input  logic                                        mem_req_ready,
    output logic [MEMORY_ADDR_WIDTH-1:0]                mem_req_addr,
    input  logic                                        mem_rsp_valid,
    input  logic [MEMORY_WIDTH-1:0]                     mem_rsp_data,
    output logic                                        output_pc_valid,
    input  logic                                        output_pc_ready,
    output logic [PC_WIDTH-1:0]                         output_pc,
    output logic [CC_ID_BITS-1:0]                       output_cc_id,
    output logic                                        accepts,
    output logic [2**CC_ID_BITS-1:0]                    elaborating_chars,
    output logic                                        running
);

    localparam int DEPTH   = 2**OUTSTANDING_LOG2;
    localparam int WINDOWS = 2**CC_ID_BITS;
    localparam int CNT_W   = OUTSTANDING_LOG2 + 1;
    localparam int OP_W    = 3;

    // Instruction word: opcode in the top OP_W bits, character operand in the low bits.
    typedef enum logic [OP_W-1:0] {
        OP_ACCEPT    = 3'd0,
        OP_SPLIT     = 3'd1,
        OP_MATCH     = 3'd2,
        OP_JMP       = 3'd3,
        OP_NOT_MATCH = 3'd4
    } opcode_e;

    logic [PC_WIDTH-1:0]         tag_pc [DEPTH];
    logic [CC_ID_BITS-1:0]       tag_cc [DEPTH];
    logic [OUTSTANDING_LOG2-1:0] tag_wr, tag_rd;
    logic [CNT_W-1:0]            inflight;

    logic [PC_WIDTH-1:0]         out_pc [DEPTH];
    logic [CC_ID_BITS-1:0]       out_cc [DEPTH];
    logic [OUTSTANDING_LOG2-1:0] out_wr, out_rd;
    logic [CNT_W-1:0]            out_count;

    logic [CNT_W-1:0]            cnt      [WINDOWS];
    logic [CNT_W-1:0]            cnt_next [WINDOWS];

    logic [CNT_W:0]              occupancy;
    logic                        credit, issue_fire, rsp_fire, push, pop, survive, accept_hit;
    logic [PC_WIDTH-1:0]         head_pc, next_pc;
    logic [CC_ID_BITS-1:0]       head_cc, next_cc;
    logic [CHARACTER_WIDTH-1:0]  head_char, operand;
    logic                        head_eos;
    opcode_e                     opcode;
    logic                        rsp_unused;

    // Credit covers both buffers so a response can always be absorbed without back-pressure.
    assign occupancy      = {1'b0, inflight} + {1'b0, out_count};
    assign credit         = occupancy < (CNT_W+1)'(DEPTH);
    assign mem_req_valid  = input_pc_valid & credit;
    assign input_pc_ready = mem_req_ready & credit;
    assign mem_req_addr   = MEMORY_ADDR_WIDTH'(input_pc);
    assign issue_fire     = input_pc_valid & mem_req_ready & credit;

    // A response with nothing outstanding is a protocol violation and is ignored.
    assign rsp_fire   = mem_rsp_valid & (inflight != '0);
    assign head_pc    = tag_pc[tag_rd];
    assign head_cc    = tag_cc[tag_rd];
    assign next_pc    = head_pc + 1'b1;
    assign next_cc    = head_cc + 1'b1;
    assign head_char  = current_characters[int'(head_cc)*CHARACTER_WIDTH +: CHARACTER_WIDTH];
    assign head_eos   = end_of_string[head_cc];
    assign opcode     = opcode_e'(mem_rsp_data[MEMORY_WIDTH-1 -: OP_W]);
    assign operand    = mem_rsp_data[CHARACTER_WIDTH-1:0];
    assign rsp_unused = ^mem_rsp_data[MEMORY_WIDTH-OP_W-1:CHARACTER_WIDTH];

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        survive = 1'b0;
        case (opcode)
            OP_MATCH:     survive = !head_eos && (head_char == operand);
            OP_NOT_MATCH: survive = !head_eos && (head_char != operand);
            default:      survive = 1'b0;
        endcase
    end

    assign push       = rsp_fire & survive;
    assign accept_hit = rsp_fire & (opcode == OP_ACCEPT) & head_eos;
    assign pop        = output_pc_valid & output_pc_ready;

    assign output_pc_valid = out_count != '0;
    assign output_pc       = out_pc[out_rd];
    assign output_cc_id    = out_cc[out_rd];
    assign running         = (inflight != '0) || (out_count != '0);

    always_comb begin
        for (int k = 0; k < WINDOWS; k++) begin
            cnt_next[k] = cnt[k];
            if (issue_fire && input_cc_id == CC_ID_BITS'(k)) cnt_next[k] = cnt_next[k] + 1'b1;
            if (rsp_fire   && head_cc     == CC_ID_BITS'(k)) cnt_next[k] = cnt_next[k] - 1'b1;
            if (push       && next_cc     == CC_ID_BITS'(k)) cnt_next[k] = cnt_next[k] + 1'b1;
            if (pop        && output_cc_id == CC_ID_BITS'(k)) cnt_next[k] = cnt_next[k] - 1'b1;
            elaborating_chars[k] = cnt[k] != '0;
        end
    end

    // NOTE: FIFO storage is deliberately not reset; pointers and counts alone define validity.
    always_ff @(posedge clk) begin
        if (issue_fire) begin
            tag_pc[tag_wr] <= input_pc;
            tag_cc[tag_wr] <= input_cc_id;
        end
        if (push) begin
            out_pc[out_wr] <= next_pc;
            out_cc[out_wr] <= next_cc;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_wr    <= '0;
            tag_rd    <= '0;
            inflight  <= '0;
            out_wr    <= '0;
            out_rd    <= '0;
            out_count <= '0;
            accepts   <= 1'b0;
            for (int k = 0; k < WINDOWS; k++) cnt[k] <= '0;
        end else begin
            if (issue_fire) tag_wr <= tag_wr + 1'b1;
            if (rsp_fire)   tag_rd <= tag_rd + 1'b1;
            if (push)       out_wr <= out_wr + 1'b1;
            if (pop)        out_rd <= out_rd + 1'b1;
            inflight  <= inflight  + CNT_W'(issue_fire) - CNT_W'(rsp_fire);
            out_count <= out_count + CNT_W'(push)       - CNT_W'(pop);
            accepts   <= accept_hit;
            for (int k = 0; k < WINDOWS; k++) cnt[k] <= cnt_next[k];
        end
    end

endmodule

// File: tb/tb_regex_match_lane_pool.sv
// Scenario tests plus a randomized run against a queue-based model of the lane pool.
module tb_regex_match_lane_pool;

    localparam logic [2:0] OP_ACCEPT    = 3'd0;
    localparam logic [2:0] OP_MATCH     = 3'd2;
    localparam logic [2:0] OP_JMP       = 3'd3;
    localparam logic [2:0] OP_NOT_MATCH = 3'd4;
    localparam int D = 4;

    typedef struct {
        logic [8:0] pc;
        logic [1:0] cc;
    } tok_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] current_characters;
    logic [3:0]  end_of_string;
    logic        input_pc_valid, input_pc_ready;
    logic [8:0]  input_pc;
    logic [1:0]  input_cc_id;
    logic        mem_req_valid, mem_req_ready;
    logic [10:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [15:0] mem_rsp_data;
    logic        output_pc_valid, output_pc_ready;
    logic [8:0]  output_pc;
    logic [1:0]  output_cc_id;
    logic        accepts;
    logic [3:0]  elaborating_chars;
    logic        running;

    int assertions = 0;
    int failures   = 0;

    regex_match_lane_pool dut (
        .clk(clk), .rst(rst),
        .current_characters(current_characters), .end_of_string(end_of_string),
        .input_pc_valid(input_pc_valid), .input_pc_ready(input_pc_ready),
        .input_pc(input_pc), .input_cc_id(input_cc_id),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .output_pc_valid(output_pc_valid), .output_pc_ready(output_pc_ready),
        .output_pc(output_pc), .output_cc_id(output_cc_id),
        .accepts(accepts), .elaborating_chars(elaborating_chars), .running(running)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] instr(input logic [2:0] op, input logic [7:0] d);
        return {op, 5'b0, d};
    endfunction

    task automatic next();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        current_characters = '0;
        end_of_string      = '0;
        input_pc_valid     = 1'b0;
        input_pc           = '0;
        input_cc_id        = '0;
        mem_req_ready      = 1'b0;
        mem_rsp_valid      = 1'b0;
        mem_rsp_data       = '0;
        output_pc_ready    = 1'b0;
    endtask

    task automatic issue(input logic [8:0] pc, input logic [1:0] cc);
        input_pc_valid = 1'b1;
        input_pc       = pc;
        input_cc_id    = cc;
        mem_req_ready  = 1'b1;
        next();
        input_pc_valid = 1'b0;
    endtask

    task automatic respond(input logic [15:0] word);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = word;
        next();
        mem_rsp_valid = 1'b0;
    endtask

    task automatic pop_one();
        output_pc_ready = 1'b1;
        next();
        output_pc_ready = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b0;
        #1;
        assertions++; if (output_pc_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %b want 0", output_pc_valid); end
        assertions++; if (accepts !== 1'b0) begin failures++; $display("FAIL reset_accepts got %b want 0", accepts); end
        assertions++; if (running !== 1'b0) begin failures++; $display("FAIL reset_running got %b want 0", running); end
        assertions++; if (elaborating_chars !== 4'b0000) begin failures++; $display("FAIL reset_elab got %b want 0000", elaborating_chars); end
        assertions++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got %b want 0", mem_req_valid); end
        next();
        next();
        rst = 1'b1;
        next();
    endtask

    task automatic test_match_pass();
        current_characters[2*8 +: 8] = 8'h41;
        input_pc_valid = 1'b1;
        input_pc       = 9'd245;
        input_cc_id    = 2'd2;
        mem_req_ready  = 1'b1;
        #1;
        assertions++; if (input_pc_ready !== 1'b1) begin failures++; $display("FAIL match_in_ready got %b want 1", input_pc_ready); end
        assertions++; if (mem_req_valid !== 1'b1) begin failures++; $display("FAIL match_req_valid got %b want 1", mem_req_valid); end
        assertions++; if (mem_req_addr !== 11'd245) begin failures++; $display("FAIL match_req_addr got %0d want 245", mem_req_addr); end
        next();
        input_pc_valid = 1'b0;
        assertions++; if (elaborating_chars !== 4'b0100) begin failures++; $display("FAIL match_elab_issue got %b want 0100", elaborating_chars); end
        assertions++; if (running !== 1'b1) begin failures++; $display("FAIL match_running got %b want 1", running); end
        respond(instr(OP_MATCH, 8'h41));
        assertions++; if (output_pc_valid !== 1'b1) begin failures++; $display("FAIL match_out_valid got %b want 1", output_pc_valid); end
        assertions++; if (output_pc !== 9'd246 || output_cc_id !== 2'd3) begin failures++; $display("FAIL match_out_token got (%0d,%0d) want (246,3)", output_pc, output_cc_id); end
        assertions++; if (elaborating_chars !== 4'b1000) begin failures++; $display("FAIL match_elab_moved got %b want 1000", elaborating_chars); end
        pop_one();
        assertions++; if (output_pc_valid !== 1'b0 || elaborating_chars !== 4'b0000 || running !== 1'b0) begin failures++; $display("FAIL match_drained got valid=%b elab=%b running=%b want 0/0000/0", output_pc_valid, elaborating_chars, running); end
    endtask

    task automatic test_wrap();
        current_characters[3*8 +: 8] = 8'h5A;
        issue(9'd511, 2'd3);
        respond(instr(OP_MATCH, 8'h5A));
        assertions++; if (output_pc_valid !== 1'b1 || output_pc !== 9'd0 || output_cc_id !== 2'd0) begin failures++; $display("FAIL wrap_token got v=%b (%0d,%0d) want v=1 (0,0)", output_pc_valid, output_pc, output_cc_id); end
        assertions++; if (elaborating_chars !== 4'b0001) begin failures++; $display("FAIL wrap_elab got %b want 0001", elaborating_chars); end
        pop_one();
        assertions++; if (running !== 1'b0) begin failures++; $display("FAIL wrap_running got %b want 0", running); end
    endtask

    task automatic test_mismatch();
        current_characters[0 +: 8] = 8'h33;
        issue(9'd20, 2'd0);
        respond(instr(OP_NOT_MATCH, 8'h33));
        assertions++; if (output_pc_valid !== 1'b0 || running !== 1'b0 || elaborating_chars !== 4'b0000) begin failures++; $display("FAIL not_match_drop got v=%b run=%b elab=%b want 0/0/0000", output_pc_valid, running, elaborating_chars); end
        current_characters[1*8 +: 8] = 8'h44;
        end_of_string = 4'b0010;
        issue(9'd21, 2'd1);
        respond(instr(OP_MATCH, 8'h44));
        assertions++; if (output_pc_valid !== 1'b0 || running !== 1'b0 || elaborating_chars !== 4'b0000) begin failures++; $display("FAIL match_eos_drop got v=%b run=%b elab=%b want 0/0/0000", output_pc_valid, running, elaborating_chars); end
        end_of_string = '0;
    endtask

    task automatic test_credit_full();
        current_characters[0 +: 8] = 8'h55;
        for (int i = 0; i < 4; i++) issue(9'(10 + i), 2'd0);
        for (int i = 0; i < 4; i++) respond(instr(OP_MATCH, 8'h55));
        assertions++; if (output_pc_valid !== 1'b1 || output_pc !== 9'd11) begin failures++; $display("FAIL full_head got v=%b pc=%0d want v=1 pc=11", output_pc_valid, output_pc); end
        input_pc_valid = 1'b1;
        input_pc       = 9'd14;
        input_cc_id    = 2'd0;
        mem_req_ready  = 1'b1;
        #1;
        assertions++; if (input_pc_ready !== 1'b0 || mem_req_valid !== 1'b0) begin failures++; $display("FAIL full_blocked got ready=%b req=%b want 0/0", input_pc_ready, mem_req_valid); end
        output_pc_ready = 1'b1;
        #1;
        assertions++; if (input_pc_ready !== 1'b0) begin failures++; $display("FAIL full_same_cycle_pop got ready=%b want 0", input_pc_ready); end
        next();
        output_pc_ready = 1'b0;
        #1;
        assertions++; if (input_pc_ready !== 1'b1 || mem_req_valid !== 1'b1) begin failures++; $display("FAIL full_credit_back got ready=%b req=%b want 1/1", input_pc_ready, mem_req_valid); end
        next();
        input_pc_valid = 1'b0;
        respond(instr(OP_MATCH, 8'h55));
        for (int i = 0; i < 4; i++) begin
            assertions++; if (output_pc_valid !== 1'b1 || output_pc !== 9'(12 + i) || output_cc_id !== 2'd1) begin failures++; $display("FAIL full_order_%0d got v=%b (%0d,%0d) want v=1 (%0d,1)", i, output_pc_valid, output_pc, output_cc_id, 12 + i); end
            pop_one();
        end
        assertions++; if (running !== 1'b0) begin failures++; $display("FAIL full_running got %b want 0", running); end
    endtask

    task automatic test_accept();
        end_of_string = 4'b0010;
        issue(9'd7, 2'd1);
        respond(instr(OP_ACCEPT, 8'h00));
        assertions++; if (accepts !== 1'b1 || output_pc_valid !== 1'b0) begin failures++; $display("FAIL accept_pulse got acc=%b v=%b want 1/0", accepts, output_pc_valid); end
        next();
        assertions++; if (accepts !== 1'b0 || running !== 1'b0) begin failures++; $display("FAIL accept_single got acc=%b run=%b want 0/0", accepts, running); end
        end_of_string = 4'b0000;
        issue(9'd8, 2'd1);
        respond(instr(OP_ACCEPT, 8'h00));
        assertions++; if (accepts !== 1'b0 || running !== 1'b0) begin failures++; $display("FAIL accept_no_eos got acc=%b run=%b want 0/0", accepts, running); end
    endtask

    task automatic test_reset_midflight();
        current_characters[0 +: 8] = 8'h55;
        issue(9'd30, 2'd0);
        respond(instr(OP_MATCH, 8'h55));
        for (int i = 0; i < 3; i++) issue(9'(31 + i), 2'd0);
        assertions++; if (output_pc_valid !== 1'b1 || running !== 1'b1 || elaborating_chars !== 4'b0011) begin failures++; $display("FAIL midflight_pre got v=%b run=%b elab=%b want 1/1/0011", output_pc_valid, running, elaborating_chars); end
        rst = 1'b0;
        #1;
        assertions++; if (output_pc_valid !== 1'b0 || running !== 1'b0 || elaborating_chars !== 4'b0000 || accepts !== 1'b0) begin failures++; $display("FAIL midflight_reset got v=%b run=%b elab=%b acc=%b want 0/0/0000/0", output_pc_valid, running, elaborating_chars, accepts); end
        next();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) respond(instr(OP_MATCH, 8'h55));
        assertions++; if (output_pc_valid !== 1'b0 || running !== 1'b0 || elaborating_chars !== 4'b0000) begin failures++; $display("FAIL late_rsp_ignored got v=%b run=%b elab=%b want 0/0/0000", output_pc_valid, running, elaborating_chars); end
    endtask

    task automatic test_random();
        tok_t       tagq[$];
        tok_t       outq[$];
        tok_t       t;
        logic       exp_acc = 1'b0;
        logic       credit, ok;
        logic [3:0] exp_elab;
        logic [2:0] op;
        logic [7:0] ch;
        idle();
        rst = 1'b0;
        next();
        rst = 1'b1;
        next();
        for (int cyc = 0; cyc < 800; cyc++) begin
            current_characters = $urandom;
            end_of_string      = 4'($urandom & $urandom);
            input_pc_valid     = ($urandom % 4) != 0;
            input_pc           = 9'($urandom);
            input_cc_id        = 2'($urandom);
            mem_req_ready      = ($urandom % 4) != 0;
            output_pc_ready    = ($urandom % 3) == 0;
            mem_rsp_valid      = (tagq.size() > 0) && ($urandom % 2);
            case ($urandom % 4)
                0: op = OP_ACCEPT;
                1: op = OP_MATCH;
                2: op = OP_NOT_MATCH;
                default: op = OP_JMP;
            endcase
            ch = 8'($urandom);
            if (tagq.size() > 0 && ($urandom % 2)) ch = current_characters[int'(tagq[0].cc)*8 +: 8];
            mem_rsp_data = instr(op, ch);
            #1;
            credit = (tagq.size() + outq.size()) < D;
            exp_elab = '0;
            foreach (tagq[i]) exp_elab[tagq[i].cc] = 1'b1;
            foreach (outq[i]) exp_elab[outq[i].cc] = 1'b1;
            assertions++; if (input_pc_ready !== (mem_req_ready & credit) || mem_req_valid !== (input_pc_valid & credit)) begin failures++; $display("FAIL rnd_issue cyc %0d got ready=%b req=%b want %b/%b", cyc, input_pc_ready, mem_req_valid, mem_req_ready & credit, input_pc_valid & credit); end
            assertions++; if (output_pc_valid !== (outq.size() > 0)) begin failures++; $display("FAIL rnd_out_valid cyc %0d got %b want %b", cyc, output_pc_valid, outq.size() > 0); end
            if (outq.size() > 0) begin
                assertions++; if (output_pc !== outq[0].pc || output_cc_id !== outq[0].cc) begin failures++; $display("FAIL rnd_out_token cyc %0d got (%0d,%0d) want (%0d,%0d)", cyc, output_pc, output_cc_id, outq[0].pc, outq[0].cc); end
            end
            assertions++; if (accepts !== exp_acc) begin failures++; $display("FAIL rnd_accepts cyc %0d got %b want %b", cyc, accepts, exp_acc); end
            assertions++; if (running !== (tagq.size() + outq.size() > 0)) begin failures++; $display("FAIL rnd_running cyc %0d got %b want %b", cyc, running, tagq.size() + outq.size() > 0); end
            assertions++; if (elaborating_chars !== exp_elab) begin failures++; $display("FAIL rnd_elab cyc %0d got %b want %b", cyc, elaborating_chars, exp_elab); end
            exp_acc = 1'b0;
            if (output_pc_ready && outq.size() > 0) void'(outq.pop_front());
            if (mem_rsp_valid) begin
                t  = tagq.pop_front();
                ch = current_characters[int'(t.cc)*8 +: 8];
                ok = 1'b0;
                if (op == OP_MATCH)     ok = !end_of_string[t.cc] && (ch == mem_rsp_data[7:0]);
                if (op == OP_NOT_MATCH) ok = !end_of_string[t.cc] && (ch != mem_rsp_data[7:0]);
                if (op == OP_ACCEPT)    exp_acc = end_of_string[t.cc];
                if (ok) outq.push_back('{pc: 9'((int'(t.pc) + 1) % 512), cc: 2'((int'(t.cc) + 1) % 4)});
            end
            if (input_pc_valid && mem_req_ready && credit) tagq.push_back('{pc: input_pc, cc: input_cc_id});
            next();
        end
    endtask

    initial begin
        test_reset();
        test_match_pass();
        test_wrap();
        test_mismatch();
        test_credit_full();
        test_accept();
        test_reset_midflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
